// File: rtl/oled_spi_byte_transmitter.sv
// SPI mode-0 output stage for the OLED panel: a small {dc,byte} FIFO is drained MSB-first onto sclk/mosi/cs/dc.
// Bytes that are already queued are sent back to back inside one chip-select frame.
module oled_spi_byte_transmitter #(
    parameter int CLK_DIV        = 4,
    parameter int FIFO_AW        = 2,
    parameter int CS_IDLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byteIn,
    input  logic       dcIn,
    input  logic       byteValid,
    output logic       byteReady,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic       dc
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = $clog2(CLK_DIV + 1);
    localparam int GW    = $clog2(CS_IDLE_CYCLES + 1);
    localparam logic [DW-1:0]      DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0]      GAP_LAST = GW'(CS_IDLE_CYCLES - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [DW-1:0]      div_q, div_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               dc_q, dc_d;
    logic               push, pop, fifo_empty;
    logic [8:0]         head;

    assign push       = byteValid && ready_q;
    assign fifo_empty = (count_q == '0);
    // Head is read asynchronously so a pop and the shift-register load share one edge.
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dcIn, byteIn};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
        busy_d  = (count_d != '0) || (state_d != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = head[6:0];
                    mosi_d  = head[7];
                    dc_d    = head[8];
                    cs_d    = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            // Chain the next queued byte into the same frame without a gap.
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                shreg_d = head[6:0];
                                mosi_d  = head[7];
                                dc_d    = head[8];
                                bit_d   = '0;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            mosi_d  = shreg_q[6];
                            shreg_d = {shreg_q[5:0], 1'b0};
                            bit_d   = bit_q + 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            dc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            dc_q     <= dc_d;
        end
    end

    assign byteReady = ready_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs        = cs_q;
    assign dc        = dc_q;
endmodule

// File: tb/tb_oled_spi_byte_transmitter.sv
// Bench for the OLED SPI byte transmitter: a pin-level protocol model checks every cycle of two instances
// (CLK_DIV=4 and CLK_DIV=1) against a queue of accepted bytes, plus hand-computed timing literals.
module tb_oled_spi_byte_transmitter;
    localparam int CS_IDLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] bi0 = 8'h00, bi1 = 8'h00;
    logic dci0 = 1'b0, dci1 = 1'b0, bv0 = 1'b0, bv1 = 1'b0;
    logic ready0, busy0, sclk0, mosi0, cs0, dc0;
    logic ready1, busy1, sclk1, mosi1, cs1, dc1;

    always #5 clk = ~clk;

    oled_spi_byte_transmitter #(.CLK_DIV(4), .FIFO_AW(2), .CS_IDLE_CYCLES(CS_IDLE)) dut0 (
        .clk(clk), .rst_n(rst_n), .byteIn(bi0), .dcIn(dci0), .byteValid(bv0),
        .byteReady(ready0), .busy(busy0), .sclk(sclk0), .mosi(mosi0), .cs(cs0), .dc(dc0)
    );
    oled_spi_byte_transmitter #(.CLK_DIV(1), .FIFO_AW(2), .CS_IDLE_CYCLES(CS_IDLE)) dut1 (
        .clk(clk), .rst_n(rst_n), .byteIn(bi1), .dcIn(dci1), .byteValid(bv1),
        .byteReady(ready1), .busy(busy1), .sclk(sclk1), .mosi(mosi1), .cs(cs1), .dc(dc1)
    );

    logic sclk_w [2], cs_w [2], mosi_w [2], dc_w [2], busy_w [2];
    assign sclk_w[0] = sclk0; assign sclk_w[1] = sclk1;
    assign cs_w[0]   = cs0;   assign cs_w[1]   = cs1;
    assign mosi_w[0] = mosi0; assign mosi_w[1] = mosi1;
    assign dc_w[0]   = dc0;   assign dc_w[1]   = dc1;
    assign busy_w[0] = busy0; assign busy_w[1] = busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];

    int         bits_m [2];
    logic [7:0] sh_m [2];
    logic       dc_m [2];
    int         next_rise [2];
    int         last_rise [2];
    int         fall_cyc [2];
    int         rise_cs_cyc [2];
    int         burst_rises [2];
    int         last_burst_rises [2];
    int         last_low_len [2];
    int         last_gap [2];
    int         rx_count [2];
    logic [8:0] last_rx [2];
    logic       sclk_p [2], cs_p [2], mosi_p [2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the pin protocol: bytes must arrive MSB-first on sclk rises, in push order,
    // with rises every 2*div clk starting div clk after cs falls, and cs framing whole bytes.
    task automatic mon_step(input int k);
        logic s, c, m, d, avail;
        int dv;
        logic [8:0] rx, ex;
        s  = sclk_w[k];
        c  = cs_w[k];
        m  = mosi_w[k];
        d  = dc_w[k];
        dv = (k == 0) ? 4 : 1;
        if (!rst_n) begin
            bits_m[k]      = 0;
            burst_rises[k] = 0;
            rise_cs_cyc[k] = -1000;
        end else begin
            if (c) check($sformatf("sclk_idle_low%0d", k), s, 0);
            check($sformatf("mosi_change_edge%0d", k),
                  (m === mosi_p[k]) || (sclk_p[k] && !s) || (cs_p[k] && !c), 1);
            if (cs_p[k] && !c) begin
                check($sformatf("cs_gap_min%0d", k), (cyc - rise_cs_cyc[k]) >= CS_IDLE, 1);
                last_gap[k]    = cyc - rise_cs_cyc[k];
                fall_cyc[k]    = cyc;
                next_rise[k]   = cyc + dv;
                bits_m[k]      = 0;
                burst_rises[k] = 0;
            end
            if (!sclk_p[k] && s) begin
                check($sformatf("rise_cs_low%0d", k), c, 0);
                check($sformatf("rise_time%0d", k), cyc, next_rise[k]);
                next_rise[k] = cyc + 2 * dv;
                last_rise[k] = cyc;
                burst_rises[k]++;
                if (bits_m[k] == 0) dc_m[k] = d;
                else check($sformatf("dc_stable%0d", k), d, dc_m[k]);
                sh_m[k] = {sh_m[k][6:0], m};
                bits_m[k]++;
                if (bits_m[k] == 8) begin
                    bits_m[k] = 0;
                    rx = {dc_m[k], sh_m[k]};
                    last_rx[k] = rx;
                    rx_count[k]++;
                    avail = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    check($sformatf("byte_queued%0d", k), avail, 1);
                    if (avail) begin
                        ex = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("rx_byte%0d", k), rx, ex);
                    end
                end
            end
            if (!cs_p[k] && c) begin
                check($sformatf("cs_rise_whole_bytes%0d", k), bits_m[k], 0);
                check($sformatf("cs_rise_time%0d", k), cyc, last_rise[k] + 2 * dv);
                rise_cs_cyc[k]      = cyc;
                last_low_len[k]     = cyc - fall_cyc[k];
                last_burst_rises[k] = burst_rises[k];
            end
        end
        sclk_p[k] = s;
        cs_p[k]   = c;
        mosi_p[k] = m;
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    // Drives one byte for one cycle (called at a negedge); acceptance follows the registered ready.
    task automatic send(input int k, input logic [7:0] b, input logic d, output logic acc);
        if (k == 0) begin
            bi0 = b; dci0 = d; bv0 = 1'b1; acc = ready0;
            if (acc) q0.push_back({d, b});
        end else begin
            bi1 = b; dci1 = d; bv1 = 1'b1; acc = ready1;
            if (acc) q1.push_back({d, b});
        end
        @(negedge clk);
        bv0 = 1'b0;
        bv1 = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy_w[k] && cs_w[k]) break;
        end
        check($sformatf("wait_idle%0d", k), busy_w[k], 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int accepted, rxc, seen_low;
        repeat (3) @(negedge clk);
        check("rst_cs", cs0, 1);
        check("rst_sclk", sclk0, 0);
        check("rst_mosi", mosi0, 0);
        check("rst_dc", dc0, 0);
        check("rst_ready", ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_cs1", cs1, 1);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte 0xA5, command
        send(0, 8'hA5, 1'b0, acc);
        check("t1_accept", acc, 1);
        check("t1_cs_before_pop", cs0, 1);
        check("t1_busy_after_push", busy0, 1);
        @(negedge clk);
        check("t1_cs_fall", cs0, 0);
        check("t1_dc", dc0, 0);
        check("t1_mosi_bit7", mosi0, 1);
        repeat (3) @(negedge clk);
        check("t1_sclk_before_rise", sclk0, 0);
        @(negedge clk);
        check("t1_first_rise", sclk0, 1);
        repeat (63) @(negedge clk);
        check("t1_cs_held", cs0, 0);
        @(negedge clk);
        check("t1_cs_rise", cs0, 1);
        @(negedge clk);
        check("t1_busy_gap", busy0, 1);
        @(negedge clk);
        check("t1_busy_done", busy0, 0);
        check("t1_rx", last_rx[0], 9'h0A5);
        check("t1_cs_low_len", last_low_len[0], 68);
        wait_idle(0, 50);

        // 2: two bytes back to back form one 16-rise frame
        rxc = rx_count[0];
        send(0, 8'h3C, 1'b0, acc);
        send(0, 8'hFF, 1'b1, acc);
        wait_idle(0, 400);
        check("t2_rises", last_burst_rises[0], 16);
        check("t2_rx_count", rx_count[0] - rxc, 2);
        check("t2_last_rx", last_rx[0], 9'h1FF);
        check("t2_cs_low_len", last_low_len[0], 132);

        // 3: valid held for 8 cycles against a 4-deep FIFO
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            bi0 = 8'h10 + 8'(i); dci0 = 1'(i); bv0 = 1'b1;
            if (ready0) begin
                accepted++;
                q0.push_back({dci0, bi0});
            end
            @(negedge clk);
        end
        bv0 = 1'b0;
        check("t3_accepted", accepted, 5);
        check("t3_ready_low", ready0, 0);
        wait_idle(0, 1000);
        check("t3_rises", last_burst_rises[0], 40);
        check("t3_last_rx", last_rx[0], 9'h014);
        check("t3_ready_back", ready0, 1);

        // 4: asynchronous reset in the middle of 0x81 with 0x99 queued
        send(0, 8'h81, 1'b0, acc);
        send(0, 8'h99, 1'b1, acc);
        repeat (38) @(negedge clk);
        check("t4_mid_byte", cs0, 0);
        rxc = rx_count[0];
        #3 rst_n = 1'b0;
        #1;
        check("t4_rst_cs", cs0, 1);
        check("t4_rst_sclk", sclk0, 0);
        check("t4_rst_mosi", mosi0, 0);
        check("t4_rst_busy", busy0, 0);
        check("t4_rst_ready", ready0, 1);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h55, 1'b1, acc);
        wait_idle(0, 200);
        check("t4_rx", last_rx[0], 9'h155);
        check("t4_rx_count", rx_count[0] - rxc, 1);

        // 5: fastest divider
        send(1, 8'hC3, 1'b0, acc);
        wait_idle(1, 100);
        check("t5_rx", last_rx[1], 9'h0C3);
        check("t5_rises", last_burst_rises[1], 8);
        check("t5_cs_low_len", last_low_len[1], 17);

        // 6: new byte pushed the moment cs rises
        send(0, 8'h01, 1'b0, acc);
        seen_low = 0;
        for (int i = 0; i < 300; i++) begin
            if (!cs0) seen_low = 1;
            if (cs0 && seen_low != 0) break;
            @(negedge clk);
        end
        check("t6_cs_rise", cs0, 1);
        send(0, 8'h02, 1'b1, acc);
        check("t6_accept", acc, 1);
        wait_idle(0, 300);
        check("t6_rx", last_rx[0], 9'h102);
        check("t6_gap_min", last_gap[0] >= CS_IDLE, 1);

        check("end_q0_empty", q0.size(), 0);
        check("end_q1_empty", q1.size(), 0);
        check("end_ready", ready0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
